// File: rtl/adsr_envelope.sv
// ADSR envelope generator, advanced once per sample tick.
//
// The output is a non-negative signed Q1.(DATA_WIDTH-1) gain that feeds the
// modulator input of the downstream amplitude modulator. Full scale is
// 2^(DATA_WIDTH-1)-1, which represents approximately 1.0.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   sample_en_i      one-cycle sample tick; the envelope only moves on ticks
//   gate_i           note gate, high while the key is held
//   attack_rate_i    level increment per tick in ATTACK
//   decay_rate_i     level decrement per tick in DECAY
//   sustain_level_i  level held in SUSTAIN, tracked live on every tick
//   release_rate_i   level decrement per tick in RELEASE
//   env_o            signed envelope, always {1'b0, level}
//   valid_o          pulses for the one cycle after each tick
//   state_o          IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   busy_o           high whenever the state is not IDLE
module adsr_envelope #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RATE_WIDTH = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sample_en_i,
    input  logic                  gate_i,
    input  logic [RATE_WIDTH-1:0] attack_rate_i,
    input  logic [RATE_WIDTH-1:0] decay_rate_i,
    input  logic [DATA_WIDTH-2:0] sustain_level_i,
    input  logic [RATE_WIDTH-1:0] release_rate_i,
    output logic [DATA_WIDTH-1:0] env_o,
    output logic                  valid_o,
    output logic [2:0]            state_o,
    output logic                  busy_o
);

    // Level register width; one bit narrower than the signed output.
    localparam int unsigned LevelWidth = DATA_WIDTH - 1;
    localparam int unsigned PadWidth   = DATA_WIDTH - RATE_WIDTH;

    // Full scale, expressed in the guard-bit-extended domain.
    localparam logic [DATA_WIDTH-1:0] LevelMaxExt = {1'b0, {LevelWidth{1'b1}}};

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    state_e                state_q, state_d;
    state_e                gate_state;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  valid_q;

    // All arithmetic carries one guard bit above the level so that sums
    // and comparisons never wrap.
    logic [DATA_WIDTH-1:0] level_ext;
    logic [DATA_WIDTH-1:0] attack_ext;
    logic [DATA_WIDTH-1:0] decay_ext;
    logic [DATA_WIDTH-1:0] release_ext;
    logic [DATA_WIDTH-1:0] sustain_ext;
    logic [DATA_WIDTH-1:0] attack_sum;
    logic [DATA_WIDTH-1:0] decay_floor;
    logic [DATA_WIDTH-1:0] decay_diff;
    logic [DATA_WIDTH-1:0] release_diff;

    assign level_ext   = {1'b0, level_q};
    assign attack_ext  = {{PadWidth{1'b0}}, attack_rate_i};
    assign decay_ext   = {{PadWidth{1'b0}}, decay_rate_i};
    assign release_ext = {{PadWidth{1'b0}}, release_rate_i};
    assign sustain_ext = {1'b0, sustain_level_i};

    // Sustain is at most 2^(W-1)-1 and a rate at most 2^(W-1)-1, so the
    // sum fits in W bits without overflow.
    assign attack_sum   = level_ext + attack_ext;
    assign decay_floor  = sustain_ext + decay_ext;
    // Only used when level exceeds the subtrahend, so these never underflow.
    assign decay_diff   = level_ext - decay_ext;
    assign release_diff = level_ext - release_ext;

    // Gate evaluation: the state whose level rule applies on this tick.
    always_comb begin
        gate_state = state_q;
        if (gate_i && (state_q == StIdle || state_q == StRelease)) begin
            // Legato retrigger: the level carries over into ATTACK.
            gate_state = StAttack;
        end else if (!gate_i &&
                     (state_q == StAttack || state_q == StDecay ||
                      state_q == StSustain)) begin
            gate_state = StRelease;
        end
    end

    // Level update for the state chosen by gate evaluation, same tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (sample_en_i) begin
            state_d = gate_state;
            case (gate_state)
                StAttack: begin
                    // A zero rate means an instantaneous attack.
                    if (attack_rate_i == '0 || attack_sum >= LevelMaxExt) begin
                        level_d = '1;
                        state_d = StDecay;
                    end else begin
                        level_d = attack_sum[LevelWidth-1:0];
                    end
                end
                StDecay: begin
                    // Also covers entry below sustain: the level snaps up.
                    if (decay_rate_i == '0 || level_ext <= decay_floor) begin
                        level_d = sustain_level_i;
                        state_d = StSustain;
                    end else begin
                        level_d = decay_diff[LevelWidth-1:0];
                    end
                end
                StSustain: begin
                    level_d = sustain_level_i;
                end
                StRelease: begin
                    if (release_rate_i == '0 || level_ext <= release_ext) begin
                        level_d = '0;
                        state_d = StIdle;
                    end else begin
                        level_d = release_diff[LevelWidth-1:0];
                    end
                end
                default: begin
                    // IDLE, and recovery from any unused encoding.
                    level_d = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            valid_q <= sample_en_i;
        end
    end

    // Sign bit tied low so the downstream multiply never inverts the carrier.
    assign env_o   = {1'b0, level_q};
    assign valid_o = valid_q;
    assign state_o = state_q;
    assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

    localparam int DW  = 16;
    localparam int RW  = 15;
    localparam int MAX = 32767;

    logic          clk;
    logic          rst_n;
    logic          sample_en;
    logic          gate;
    logic [RW-1:0] attack_rate;
    logic [RW-1:0] decay_rate;
    logic [DW-2:0] sustain_level;
    logic [RW-1:0] release_rate;
    logic [DW-1:0] env;
    logic          valid;
    logic [2:0]    state;
    logic          busy;

    int n_cmp;
    int n_err;

    // Reference model: plain integers, phase numbers as in the state_o map.
    int m_phase;
    int m_level;

    adsr_envelope #(
        .DATA_WIDTH(DW),
        .RATE_WIDTH(RW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_en_i    (sample_en),
        .gate_i         (gate),
        .attack_rate_i  (attack_rate),
        .decay_rate_i   (decay_rate),
        .sustain_level_i(sustain_level),
        .release_rate_i (release_rate),
        .env_o          (env),
        .valid_o        (valid),
        .state_o        (state),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One envelope step computed directly from the envelope rules.
    function automatic void model_step();
        int ph;
        int ar;
        int dr;
        int rr;
        int sl;
        ph = m_phase;
        ar = int'(attack_rate);
        dr = int'(decay_rate);
        rr = int'(release_rate);
        sl = int'(sustain_level);
        if (gate && (ph == 0 || ph == 4)) ph = 1;
        else if (!gate && ph >= 1 && ph <= 3) ph = 4;
        if (ph == 1) begin
            if (ar == 0 || m_level + ar >= MAX) begin
                m_level = MAX;
                ph = 2;
            end else begin
                m_level = m_level + ar;
            end
        end else if (ph == 2) begin
            if (dr == 0 || m_level <= sl + dr) begin
                m_level = sl;
                ph = 3;
            end else begin
                m_level = m_level - dr;
            end
        end else if (ph == 3) begin
            m_level = sl;
        end else if (ph == 4) begin
            if (rr == 0 || m_level <= rr) begin
                m_level = 0;
                ph = 0;
            end else begin
                m_level = m_level - rr;
            end
        end else begin
            m_level = 0;
        end
        m_phase = ph;
    endfunction

    // Drives one isolated tick; outputs are then settled at #1 after the edge.
    task automatic tick();
        @(negedge clk);
        sample_en = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (env !== 16'd0 || state !== 3'd0 || busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: env=%0d state=%0d busy=%0b valid=%0b required 0/0/0/0",
                     env, state, busy, valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gate = 1'b1;
        attack_rate = 15'd8192;
        tick();
        tick();
        n_cmp++;
        if (env !== 16'd16384 || state !== 3'd1) begin
            n_err++;
            $display("FAIL reset_preattack: env=%0d state=%0d required 16384/1", env, state);
        end
        // Asynchronous reset mid-attack, checked before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_phase = 0;
        m_level = 0;
        n_cmp++;
        if (env !== 16'd0 || state !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: env=%0d state=%0d busy=%0b required 0/0/0",
                     env, state, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        gate = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        n_cmp++;
        if (env !== 16'd0 || state !== 3'd0 || busy !== 1'b0 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_gate_low_tick: env=%0d state=%0d busy=%0b valid=%0b required 0/0/0/1",
                     env, state, busy, valid);
        end
    endtask

    task automatic test_attack();
        int exp_env [4];
        int exp_st [4];
        exp_env = '{8192, 16384, 24576, 32767};
        exp_st  = '{1, 1, 1, 2};
        gate = 1'b1;
        attack_rate = 15'd8192;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (env !== 16'(exp_env[i]) || state !== 3'(exp_st[i]) || valid !== 1'b1) begin
                n_err++;
                $display("FAIL attack_step%0d: env=%0d state=%0d valid=%0b required %0d/%0d/1",
                         i, env, state, valid, exp_env[i], exp_st[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (valid !== 1'b0) begin
                n_err++;
                $display("FAIL attack_valid_width%0d: valid=%0b required 0", i, valid);
            end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_decay_sustain();
        int exp_env [4];
        int exp_st [4];
        exp_env = '{22767, 12767, 12000, 5000};
        exp_st  = '{2, 2, 3, 3};
        decay_rate = 15'd10000;
        sustain_level = 15'd12000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sustain_level = 15'd5000;
            tick();
            n_cmp++;
            if (env !== 16'(exp_env[i]) || state !== 3'(exp_st[i])) begin
                n_err++;
                $display("FAIL decay_step%0d: env=%0d state=%0d required %0d/%0d",
                         i, env, state, exp_env[i], exp_st[i]);
            end
        end
    endtask

    task automatic test_release();
        int exp_env [3];
        int exp_st [3];
        exp_env = '{3000, 1000, 0};
        exp_st  = '{4, 4, 0};
        gate = 1'b0;
        release_rate = 15'd2000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (env !== 16'(exp_env[i]) || state !== 3'(exp_st[i]) ||
                busy !== (exp_st[i] != 0)) begin
                n_err++;
                $display("FAIL release_step%0d: env=%0d state=%0d busy=%0b required %0d/%0d",
                         i, env, state, busy, exp_env[i], exp_st[i]);
            end
        end
    endtask

    task automatic test_legato();
        gate = 1'b1;
        attack_rate = 15'd8192;
        tick();
        gate = 1'b0;
        release_rate = 15'd1000;
        tick();
        n_cmp++;
        if (env !== 16'd7192 || state !== 3'd4) begin
            n_err++;
            $display("FAIL legato_gate_off: env=%0d state=%0d required 7192/4", env, state);
        end
        gate = 1'b1;
        attack_rate = 15'd1000;
        tick();
        n_cmp++;
        if (env !== 16'd8192 || state !== 3'd1) begin
            n_err++;
            $display("FAIL legato_retrigger: env=%0d state=%0d required 8192/1", env, state);
        end
    endtask

    task automatic test_zero_rates();
        attack_rate = '0;
        decay_rate = '0;
        release_rate = '0;
        sustain_level = 15'd20000;
        gate = 1'b1;
        tick();
        n_cmp++;
        if (env !== 16'd32767 || state !== 3'd2) begin
            n_err++;
            $display("FAIL zero_attack: env=%0d state=%0d required 32767/2", env, state);
        end
        tick();
        n_cmp++;
        if (env !== 16'd20000 || state !== 3'd3) begin
            n_err++;
            $display("FAIL zero_decay: env=%0d state=%0d required 20000/3", env, state);
        end
        gate = 1'b0;
        tick();
        n_cmp++;
        if (env !== 16'd0 || state !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_release: env=%0d state=%0d busy=%0b required 0/0/0",
                     env, state, busy);
        end
    endtask

    task automatic test_no_tick();
        int bad;
        gate = 1'b1;
        attack_rate = 15'd5000;
        tick();
        n_cmp++;
        if (env !== 16'd5000 || state !== 3'd1) begin
            n_err++;
            $display("FAIL hold_setup: env=%0d state=%0d required 5000/1", env, state);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            gate = 1'($urandom);
            attack_rate = RW'($urandom);
            decay_rate = RW'($urandom);
            release_rate = RW'($urandom);
            sustain_level = 15'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if (env !== 16'd5000 || valid !== 1'b0 || state !== 3'd1) begin
                n_err++;
                bad++;
                if (bad < 5)
                    $display("FAIL hold_cycle%0d: env=%0d valid=%0b state=%0d required 5000/0/1",
                             i, env, valid, state);
            end
        end
    endtask

    task automatic pick_rate(output logic [RW-1:0] r);
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) r = '0;
        else if (sel < 6) r = RW'($urandom_range(1, 2500));
        else r = RW'($urandom_range(1, MAX));
    endtask

    task automatic test_random();
        int gap;
        int bad;
        logic [RW-1:0] r;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) gate = ~gate;
            pick_rate(r);
            attack_rate = r;
            pick_rate(r);
            decay_rate = r;
            pick_rate(r);
            release_rate = r;
            if ($urandom_range(0, 3) == 0) sustain_level = 15'($urandom);
            sample_en = 1'b1;
            model_step();
            @(posedge clk);
            #1;
            n_cmp++;
            if (env !== 16'(m_level) || state !== 3'(m_phase) ||
                busy !== (m_phase != 0) || valid !== 1'b1 || env[DW-1] !== 1'b0) begin
                n_err++;
                bad++;
                if (bad < 8)
                    $display("FAIL random_tick%0d: env=%0d state=%0d busy=%0b valid=%0b required %0d/%0d/%0b/1",
                             i, env, state, busy, valid, m_level, m_phase, m_phase != 0);
            end
            // Zero gap gives back-to-back ticks on consecutive cycles.
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                sample_en = 1'b0;
                @(posedge clk);
                #1;
                n_cmp++;
                if (env !== 16'(m_level) || valid !== 1'b0) begin
                    n_err++;
                    bad++;
                    if (bad < 8)
                        $display("FAIL random_gap%0d: env=%0d valid=%0b required %0d/0",
                                 i, env, valid, m_level);
                end
            end
        end
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_phase = 0;
        m_level = 0;
        sample_en = 1'b0;
        gate = 1'b0;
        attack_rate = '0;
        decay_rate = '0;
        sustain_level = '0;
        release_rate = '0;
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release();
        test_legato();
        test_zero_rates();
        test_no_tick();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Sample-rate ADSR envelope generator that produces the low-frequency modulating signal for the amplitude modulator stage.
- Sits directly upstream of the amplitude modulator. env_o drives its modulator input; the carrier comes from the oscillator path.
- Output is a non-negative signed Q1.(DATA_WIDTH-1) gain. Full scale is 2^(DATA_WIDTH-1)-1, which represents approximately 1.0.

Parameters:
- DATA_WIDTH, 16, width of env_o and of the amplitude modulator data path.
- RATE_WIDTH, 15, width of the attack, decay and release rate inputs. Must be <= DATA_WIDTH-1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- sample_en_i  in  1  one-cycle sample tick; the envelope advances only on ticks
- gate_i  in  1  note gate; high = key held
- attack_rate_i  in  RATE_WIDTH  level increment per tick in ATTACK (unsigned)
- decay_rate_i  in  RATE_WIDTH  level decrement per tick in DECAY (unsigned)
- sustain_level_i  in  DATA_WIDTH-1  sustain target level (unsigned)
- release_rate_i  in  RATE_WIDTH  level decrement per tick in RELEASE (unsigned)
- env_o  out  DATA_WIDTH  signed envelope = {1'b0, level}
- valid_o  out  1  one-cycle pulse when env_o has been updated
- state_o  out  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- busy_o  out  1  high when state != IDLE

Behaviour:
- Constants and storage: MAX = 2^(DATA_WIDTH-1)-1. Internal level register is unsigned, DATA_WIDTH-1 bits. All arithmetic uses one extra guard bit and saturates; no wrap-around, ever.
- Reset (rst_ni low, asynchronous): state=IDLE, level=0, env_o=0, valid_o=0, busy_o=0, state_o=0. Takes effect mid-envelope immediately, with no release tail. Leaving reset is synchronous to clk_i.
- No tick (sample_en_i low): state, level and env_o hold; valid_o=0.
- On a tick, step 1 — gate evaluation (level-sensitive, sampled only on ticks):
  - gate_i=1 and state in {IDLE, RELEASE}: next state = ATTACK. Retrigger is legato; level is not reset.
  - gate_i=0 and state in {ATTACK, DECAY, SUSTAIN}: next state = RELEASE.
- On a tick, step 2 — level update, using the rule of the state chosen in step 1, in the same tick:
  - ATTACK: level = min(level + attack_rate_i, MAX). Reaching MAX sets next state = DECAY.
  - DECAY: if level <= sustain_level_i + decay_rate_i, then level = sustain_level_i and next state = SUSTAIN; else level -= decay_rate_i.
  - SUSTAIN: level = sustain_level_i. Tracks live changes to sustain_level_i, applied on ticks only.
  - RELEASE: if level <= release_rate_i, then level = 0 and next state = IDLE; else level -= release_rate_i.
  - IDLE: level = 0.
- Zero rates mean instantaneous: attack_rate_i=0 jumps to MAX; decay_rate_i=0 jumps to sustain_level_i; release_rate_i=0 jumps to 0. In each case the same tick also advances the state, as above.
- Level below sustain at DECAY entry: the DECAY rule already covers this case. The level snaps up to sustain_level_i, and the state goes to SUSTAIN on that tick.
- Latency: env_o, state_o and busy_o update on the clock edge where sample_en_i=1. valid_o is high for exactly the following cycle. Throughput is one update per tick, and back-to-back ticks on consecutive cycles are legal.
- Rates and sustain_level_i are sampled live on every tick. There are no shadow registers.
- Invariant: env_o[DATA_WIDTH-1] is always 0, so the downstream multiply never flips the carrier's phase.

Test Plan:
- Reset mid-operation: drive rst_ni low during ATTACK at level 16384. Same cycle, without any clock edge: env_o=0, state_o=0, busy_o=0. After rst_ni returns high: no output change until a tick with gate_i=1.
- Attack ramp: gate_i=1, attack_rate_i=8192, one tick every 4 clocks. env_o must read 8192, 16384, 24576, then 32767 with state_o=2 on the 4th tick. valid_o pulses 1 cycle after each tick.
- Decay and sustain: start at 32767, decay_rate_i=10000, sustain_level_i=12000. env_o must read 22767, then 12767, then 12000 with state_o=3. Then change sustain_level_i to 5000: the next tick gives env_o=5000.
- Release: gate_i=0 from sustain 5000, release_rate_i=2000. env_o must read 3000, 1000, then 0 with state_o=0 and busy_o=0.
- Mid-attack gate-off and legato retrigger: gate drops at level 8192 with release_rate_i=1000, so the next tick gives 7192 in RELEASE. Gate returns with attack_rate_i=1000, so the next tick gives 8192 in ATTACK.
- Zero rates and tick gating:
  - All rates 0, gate_i=1: first tick gives 32767 (DECAY). Second tick gives sustain_level_i (SUSTAIN).
  - Gate_i=0, one tick: env_o=0 and state IDLE.
  - With sample_en_i held low for 100 cycles, env_o is constant and valid_o stays 0.
